qoi_byte_packer: RTL
====================

// Module: qoi_byte_packer
// PURPOSE
//  Downstream of the QOI pixel encoder. Takes its variable-length chunk output (0-5 bytes/cycle).
//  Emits a single valid/ready byte stream forming a complete .qoi file:
//  14-byte header, chunk bytes in order, 8-byte end marker.
//  An internal byte FIFO absorbs bursts. in_ready tells the pixel source when to stall.
// PARAMETERS
//  DEPTH      16   byte FIFO entries; power of two, >= 8
//  CNT_W      32   width of out_count
// PORTS
//  clk         in   1       clock; all state on rising edge
//  rst         in   1       reset; asynchronous, active-high
//  start       in   1       pulse: latch header fields, begin a file (honoured in IDLE/DONE only)
//  img_width   in   32      header width, sampled on start
//  img_height  in   32      header height, sampled on start
//  channels    in   8       header channels (3/4), sampled on start
//  colorspace  in   8       header colorspace (0/1), sampled on start
//  chunk_data  in   40      chunk bytes; byte k = chunk_data[8k+7:8k]; byte 0 sent first
//  chunk_len   in   3       valid bytes this cycle; 0 = none; legal 0,1,2,4,5
//  in_ready    out  1       FIFO free >= 5 and state in {HEADER,STREAM}
//  finish      in   1       pulse: last chunk already presented, append end marker
//  out_data    out  8       stream byte
//  out_valid   out  1       out_data valid
//  out_ready   in   1       sink accepts byte when out_valid & out_ready
//  out_count   out  CNT_W   bytes accepted by sink since start
//  done        out  1       level: end marker fully sent; cleared by next start
//  err         out  1       sticky: overflow or illegal chunk_len; cleared by start or rst
// BEHAVIOUR
//  Reset values: out_valid=0, out_data=0, in_ready=0, done=0, err=0, out_count=0, FIFO empty, state IDLE.
//  States:
//   - IDLE: on start -> HEADER; hdr_idx=0; out_count=0; err=0.
//   - HEADER: emits 71 6f 69 66, width BE, height BE, channels, colorspace.
//     Advances on handshake; after byte 13 -> STREAM. Chunks are accepted into the FIFO meanwhile.
//   - STREAM: out_data = FIFO head. finish is latched (fin_pend).
//     When fin_pend and FIFO empty -> TRAILER.
//   - TRAILER: emits 00 x7 then 01; after the 01 handshake -> DONE.
//   - DONE: done=1, in_ready=0; start -> HEADER.
//  Write side:
//   - chunk_len bytes 0..len-1 are pushed in one cycle, in order.
//   - A chunk with len > free space is dropped whole and sets err; no partial writes.
//   - len in {3,6,7} is dropped and sets err.
//   - Chunks arriving in IDLE/DONE or after fin_pend are ignored (no err).
//  Read side:
//   - One byte per handshake. Simultaneous push and pop in one cycle is legal.
//   - free is computed after the same-cycle pop is excluded: the conservative value is used.
//   - in_ready is combinational from registered count only.
//  Latency: a byte written in cycle N appears on out_data no earlier than N+1 (registered FIFO state).
//  out_valid/out_data hold stable while out_valid & !out_ready (AXI-style).
//  Pointers wrap modulo DEPTH. count is a $clog2(DEPTH)+1-bit field and distinguishes full from empty.
//  out_count wraps modulo 2^CNT_W.
//  finish in HEADER is latched and honoured after the header.
//  finish together with a chunk: the chunk is accepted first.
//  start outside IDLE/DONE is ignored.
//  rst mid-file aborts immediately; no trailer is emitted.
// STRUCTURE
//  qoi_pkg (shared package):
//   - QOI_MAGIC=32'h716f6966, QOI_HDR_LEN=14, QOI_END_LEN=8, QOI_MAX_CHUNK=5.
//   - QOI_OP_* opcodes; packer state enum.
//  Sub-module qoi_byte_fifo: DEPTH-entry, multi-byte (0-5) push, single pop, count output.
//  Top: FSM, header/trailer byte mux, push qualification, err/out_count logic.
// TESTING
//  1. start with w=2,h=1,ch=4,cs=0, finish at once, out_ready=1 ->
//     71 6f 69 66 00 00 00 02 00 00 00 01 04 00 + 00x7 01; out_count=22; done=1.
//  2. In STREAM: chunk len=5 {fe? ff,10,20,30,40}, then len=1 {c3}, then len=2 {a5,88} ->
//     ff 10 20 30 40 c3 a5 88 in order.
//  3. DEPTH=16, out_ready=0, push len=5 x3 -> in_ready=0 once count=15.
//     A 4th len=5 push sets err, count stays 15.
//  4. chunk_len=3 in STREAM -> dropped, err=1, out_count unchanged.
//  5. out_ready toggling 1010... over 100 random chunks -> byte sequence equals the
//     scoreboard's concatenation of the chunks; out_data stable while stalled.
//  6. rst asserted mid-STREAM with FIFO half full -> next cycle out_valid=0, state IDLE, err=0, done=0.

Source files
------------

// File: rtl/qoi_pkg.sv
// Shared definitions for the QOI output path.
//   - File framing constants (magic, header/end-marker lengths, max chunk size).
//   - QOI chunk opcodes, kept here so encoder and packer agree on them.
//   - Byte packer FSM state type.
//   - Helpers: chunk length legality, header byte selection.
package qoi_pkg;

  localparam logic [31:0] QOI_MAGIC     = 32'h716f6966;  // "qoif"
  localparam int unsigned QOI_HDR_LEN   = 14;
  localparam int unsigned QOI_END_LEN   = 8;
  localparam int unsigned QOI_MAX_CHUNK = 5;

  localparam logic [7:0] QOI_OP_INDEX = 8'h00;
  localparam logic [7:0] QOI_OP_DIFF  = 8'h40;
  localparam logic [7:0] QOI_OP_LUMA  = 8'h80;
  localparam logic [7:0] QOI_OP_RUN   = 8'hc0;
  localparam logic [7:0] QOI_OP_RGB   = 8'hfe;
  localparam logic [7:0] QOI_OP_RGBA  = 8'hff;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StStream,
    StTrailer,
    StDone
  } packer_state_e;

  // Encoder chunks are only ever 1, 2, 4 or 5 bytes long (0 = no chunk).
  function automatic logic chunk_len_legal(input logic [2:0] len);
    return !(len == 3'd3 || len == 3'd6 || len == 3'd7);
  endfunction

  // Header byte idx of the 14-byte file header; multi-byte fields are big-endian.
  function automatic logic [7:0] header_byte(input logic [3:0]  idx,
                                             input logic [31:0] width,
                                             input logic [31:0] height,
                                             input logic [7:0]  channels,
                                             input logic [7:0]  colorspace);
    logic [7:0] b;
    case (idx)
      4'd0:    b = QOI_MAGIC[31:24];
      4'd1:    b = QOI_MAGIC[23:16];
      4'd2:    b = QOI_MAGIC[15:8];
      4'd3:    b = QOI_MAGIC[7:0];
      4'd4:    b = width[31:24];
      4'd5:    b = width[23:16];
      4'd6:    b = width[15:8];
      4'd7:    b = width[7:0];
      4'd8:    b = height[31:24];
      4'd9:    b = height[23:16];
      4'd10:   b = height[15:8];
      4'd11:   b = height[7:0];
      4'd12:   b = channels;
      4'd13:   b = colorspace;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/qoi_byte_fifo.sv
// Byte FIFO with a 0-5 byte push and a single-byte pop per cycle.
//   clk, rst   : clock, asynchronous active-high reset
//   push_len   : bytes to write this cycle (caller guarantees push_len <= free space)
//   push_data  : byte k = push_data[8k+7:8k], byte 0 written first
//   pop        : remove head byte (caller guarantees count != 0)
//   head       : byte at the read pointer
//   count      : occupancy, one bit wider than the pointers so full != empty
module qoi_byte_fifo
  import qoi_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    push_len,
  input  logic [39:0]   push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(QOI_MAX_CHUNK); k++) begin
      if (3'(k) < push_len) begin
        mem[wr_ptr_q + AW'(k)] <= push_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_len);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(push_len) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/qoi_byte_packer.sv
// Turns the pixel encoder's variable-length chunks into a complete .qoi byte stream:
// 14-byte header, buffered chunk bytes, 8-byte end marker, on one valid/ready output.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : begin a file, latch header fields (IDLE/DONE only)
//   img_width/height, channels, colorspace : header fields, sampled on start
//   chunk_data/len  : 0-5 chunk bytes per cycle, byte 0 first
//   in_ready        : room for a maximal chunk and a file in progress
//   finish          : last chunk presented; append end marker once drained
//   out_data/valid/ready : output byte stream
//   out_count       : bytes accepted by the sink since start
//   done            : end marker fully sent
//   err             : sticky overflow / illegal chunk length
module qoi_byte_packer
  import qoi_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      img_width,
  input  logic [31:0]      img_height,
  input  logic [7:0]       channels,
  input  logic [7:0]       colorspace,
  input  logic [39:0]      chunk_data,
  input  logic [2:0]       chunk_len,
  output logic             in_ready,
  input  logic             finish,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             done,
  output logic             err
);

  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam logic [3:0]  HdrLast  = 4'(QOI_HDR_LEN - 1);
  localparam logic [3:0]  EndLast  = 4'(QOI_END_LEN - 1);

  packer_state_e    state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             fin_pend_q, fin_pend_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [31:0]      hdr_w_q, hdr_h_q;
  logic [7:0]       hdr_ch_q, hdr_cs_q;

  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    fifo_free;
  logic [7:0]       fifo_head;
  logic [2:0]       push_len;
  logic             pop;
  logic             accept_state;
  logic             chunk_live;
  logic             chunk_bad;
  logic             start_ok;
  logic             hs;

  assign start_ok     = start && (state_q == StIdle || state_q == StDone);
  assign accept_state = (state_q == StHeader) || (state_q == StStream);

  // Free space ignores any same-cycle pop, so a push never relies on a byte leaving.
  assign fifo_free  = CW'(DEPTH) - fifo_count;
  assign chunk_live = accept_state && !fin_pend_q && (chunk_len != 3'd0);
  assign chunk_bad  = chunk_live &&
                      (!chunk_len_legal(chunk_len) || (CW'(chunk_len) > fifo_free));
  assign push_len   = (chunk_live && !chunk_bad) ? chunk_len : 3'd0;

  assign in_ready = accept_state && (fifo_free >= CW'(QOI_MAX_CHUNK));

  assign hs  = out_valid && out_ready;
  assign pop = (state_q == StStream) && hs;

  qoi_byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_len (push_len),
    .push_data(chunk_data),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  // Output mux: every source is registered state, so data holds while stalled.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      StHeader: begin
        out_valid = 1'b1;
        out_data  = header_byte(idx_q, hdr_w_q, hdr_h_q, hdr_ch_q, hdr_cs_q);
      end
      StStream: begin
        out_valid = (fifo_count != '0);
        out_data  = fifo_head;
      end
      StTrailer: begin
        out_valid = 1'b1;
        out_data  = (idx_q == EndLast) ? 8'h01 : 8'h00;
      end
      default: begin
        out_valid = 1'b0;
        out_data  = 8'h00;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fin_pend_d  = fin_pend_q;
    err_d       = err_q;
    out_count_d = out_count_q;

    if (hs) begin
      out_count_d = out_count_q + CNT_W'(1);
    end
    if (chunk_bad) begin
      err_d = 1'b1;
    end
    // A chunk in the same cycle was already qualified against the old fin_pend.
    if (finish && accept_state) begin
      fin_pend_d = 1'b1;
    end

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StHeader;
          idx_d       = 4'd0;
          fin_pend_d  = 1'b0;
          err_d       = 1'b0;
          out_count_d = '0;
        end
      end
      StHeader: begin
        if (hs) begin
          if (idx_q == HdrLast) begin
            state_d = StStream;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StStream: begin
        if (fin_pend_q && (fifo_count == '0)) begin
          state_d = StTrailer;
          idx_d   = 4'd0;
        end
      end
      StTrailer: begin
        if (hs) begin
          if (idx_q == EndLast) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= 4'd0;
      fin_pend_q  <= 1'b0;
      err_q       <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fin_pend_q  <= fin_pend_d;
      err_q       <= err_d;
      out_count_q <= out_count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_w_q  <= '0;
      hdr_h_q  <= '0;
      hdr_ch_q <= '0;
      hdr_cs_q <= '0;
    end else if (start_ok) begin
      hdr_w_q  <= img_width;
      hdr_h_q  <= img_height;
      hdr_ch_q <= channels;
      hdr_cs_q <= colorspace;
    end
  end

  assign out_count = out_count_q;
  assign done      = (state_q == StDone);
  assign err       = err_q;

endmodule
